// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a single-port data SRAM.
// Turns byte-addressed RISC-V loads/stores into one or two word-addressed SRAM cycles.
module lsu_mem_ctrl #(
    parameter int AWIDTH = 12
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              REQ,
    input  logic              WE,
    input  logic [2:0]        FUNCT3,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       WDATA,
    output logic              READY,
    output logic              DONE,
    output logic              ERR,
    output logic [31:0]       RDATA,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [AWIDTH-1:0] MEM_ADDR,
    output logic [3:0]        MEM_BE,
    output logic [31:0]       MEM_DI,
    input  logic [31:0]       MEM_DOUT
);

    typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [3:0]  r_be_hi;
    logic [31:0] r_di_hi;
    logic [31:0] r_w0;

    logic [3:0]  w_size;
    logic [7:0]  w_m;
    logic [63:0] w_sh;
    logic        w_legal;
    logic        w_split;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic [31:0] w_ld;
    logic        w_unused;

    function automatic logic legal_op(input logic we, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: legal_op = 1'b1;
            3'b100, 3'b101:         legal_op = !we;
            default:                legal_op = 1'b0;
        endcase
    endfunction

    // f3[2] selects zero extension for LBU/LHU
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] v);
        case (f3[1:0])
            2'b00:   extend_load = {{24{v[7] & ~f3[2]}}, v[7:0]};
            2'b01:   extend_load = {{16{v[15] & ~f3[2]}}, v[15:0]};
            default: extend_load = v;
        endcase
    endfunction

    always_comb begin
        w_size = 4'hF;
        case (FUNCT3[1:0])
            2'b00:   w_size = 4'h1;
            2'b01:   w_size = 4'h3;
            default: w_size = 4'hF;
        endcase
    end

    assign w_m      = {4'b0000, w_size} << ADDR[1:0];
    assign w_sh     = {32'b0, WDATA} << {ADDR[1:0], 3'b000};
    assign w_legal  = legal_op(WE, FUNCT3);
    assign w_split  = (r_be_hi != 4'b0000);
    assign w_unused = ^ADDR[31:AWIDTH+2];

    // Single-cycle loads see {0, DOUT}; split loads see {DOUT(word+1), W0}
    assign w_hi = (r_state == S_ACC1) ? MEM_DOUT : 32'b0;
    assign w_lo = (r_state == S_ACC1) ? r_w0 : MEM_DOUT;
    assign w_ld = extend_load(r_f3, 32'({w_hi, w_lo} >> {r_off, 3'b000}));

    always_ff @(posedge CLK) begin
        if (r_state == S_IDLE) begin
            r_we    <= WE;
            r_f3    <= FUNCT3;
            r_off   <= ADDR[1:0];
            r_be_hi <= WE ? w_m[7:4] : 4'b0000;
            r_di_hi <= w_sh[63:32];
        end
        if (r_state == S_ACC0) begin
            r_w0 <= MEM_DOUT;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state  <= S_IDLE;
            READY    <= 1'b1;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            RDATA    <= 32'b0;
            MEM_CSN  <= 1'b1;
            MEM_WEN  <= 1'b1;
            MEM_ADDR <= '0;
            MEM_BE   <= 4'b0000;
            MEM_DI   <= 32'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        READY <= 1'b0;
                        if (!w_legal) begin
                            r_state <= S_RESP;
                            DONE    <= 1'b1;
                            ERR     <= 1'b1;
                        end else begin
                            r_state  <= S_ACC0;
                            MEM_CSN  <= 1'b0;
                            MEM_WEN  <= ~WE;
                            MEM_ADDR <= ADDR[AWIDTH+1:2];
                            MEM_BE   <= WE ? w_m[3:0] : 4'b0000;
                            MEM_DI   <= WE ? w_sh[31:0] : 32'b0;
                        end
                    end
                end
                S_ACC0, S_ACC1: begin
                    // Split loads keep r_be_hi zero, so split is decided by the lane mask
                    if (r_state == S_ACC0 && (w_split || (!r_we && ({4'b0000, 4'b0001} << r_off) != 8'h00 &&
                                                          (r_f3[1:0] == 2'b10 ? r_off != 2'b00 :
                                                           r_f3[1:0] == 2'b01 ? r_off == 2'b11 : 1'b0)))) begin
                        r_state  <= S_ACC1;
                        MEM_ADDR <= MEM_ADDR + AWIDTH'(1);
                        MEM_BE   <= r_be_hi;
                        MEM_DI   <= r_we ? r_di_hi : 32'b0;
                    end else begin
                        r_state <= S_RESP;
                        DONE    <= 1'b1;
                        MEM_CSN <= 1'b1;
                        MEM_WEN <= 1'b1;
                        MEM_BE  <= 4'b0000;
                        MEM_DI  <= 32'b0;
                        if (!r_we) begin
                            RDATA <= w_ld;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    DONE    <= 1'b0;
                    ERR     <= 1'b0;
                    READY   <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: byte-level memory reference model,
// directed cases and randomized load/store traffic against a behavioural SRAM.
module tb_lsu_mem_ctrl;

    localparam int AW = 12;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          REQ;
    logic          WE;
    logic [2:0]    FUNCT3;
    logic [31:0]   ADDR;
    logic [31:0]   WDATA;
    logic          READY;
    logic          DONE;
    logic          ERR;
    logic [31:0]   RDATA;
    logic          MEM_CSN;
    logic          MEM_WEN;
    logic [AW-1:0] MEM_ADDR;
    logic [3:0]    MEM_BE;
    logic [31:0]   MEM_DI;
    logic [31:0]   MEM_DOUT;

    logic [31:0] sram    [0:4095];
    logic [31:0] ref_mem [0:4095];

    int total = 0;
    int bad   = 0;

    // observations of the last transaction
    int          lat;
    int          ncyc;
    logic        o_err;
    logic        o_rdy;
    logic [31:0] o_rdata;
    logic        done_after;
    logic        rdy_after;
    logic [11:0] cadr [2];
    logic [3:0]  cbe  [2];
    logic [31:0] cdi  [2];
    logic        cwen [2];
    time         t_accept;

    // expectations of the reference model
    int          enc;
    logic [11:0] eadr [2];
    logic [3:0]  ebe  [2];
    logic [31:0] edi  [2];
    logic [31:0] exp_rdata;

    lsu_mem_ctrl #(.AWIDTH(AW)) dut (
        .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .WE(WE), .FUNCT3(FUNCT3),
        .ADDR(ADDR), .WDATA(WDATA), .READY(READY), .DONE(DONE), .ERR(ERR),
        .RDATA(RDATA), .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR),
        .MEM_BE(MEM_BE), .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT)
    );

    always #5 CLK = ~CLK;

    // SRAM: async read, enabled bytes written at the negedge of any selected cycle
    assign MEM_DOUT = sram[MEM_ADDR];
    always @(negedge CLK) begin
        if (!MEM_CSN) begin
            for (int b = 0; b < 4; b++) begin
                if (MEM_BE[b]) sram[MEM_ADDR][b*8 +: 8] = MEM_DI[b*8 +: 8];
            end
        end
    end

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) return 1'b1;
        if (f3 == 3'b100 || f3 == 3'b101) return !we;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        logic [31:0] ba;
        v = 32'b0;
        for (int i = 0; i < nbytes(f3); i++) begin
            ba = a + i;
            v[8*i +: 8] = ref_mem[ba[13:2]][8*ba[1:0] +: 8];
        end
        if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] ba;
        for (int i = 0; i < nbytes(f3); i++) begin
            ba = a + i;
            ref_mem[ba[13:2]][8*ba[1:0] +: 8] = wd[8*i +: 8];
        end
    endtask

    task automatic model_cycles(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd);
        int off;
        int k;
        off = int'(a[1:0]);
        enc = (off + nbytes(f3) > 4) ? 2 : 1;
        eadr[0] = a[13:2];
        eadr[1] = a[13:2] + 12'd1;
        ebe[0] = 4'b0; ebe[1] = 4'b0;
        edi[0] = 32'b0; edi[1] = 32'b0;
        if (we) begin
            for (int i = 0; i < nbytes(f3); i++) begin
                k = off + i;
                ebe[k/4][k%4] = 1'b1;
                edi[k/4][8*(k%4) +: 8] = wd[8*i +: 8];
            end
        end
    endtask

    task automatic poke(input int w, input logic [31:0] v);
        sram[w]    = v;
        ref_mem[w] = v;
    endtask

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        int guard;
        ncyc = 0; lat = -1; o_err = 1'b0; o_rdy = 1'b1; o_rdata = 32'b0;
        done_after = 1'b1; rdy_after = 1'b0;
        guard = 0;
        @(negedge CLK);
        while (!READY && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = a; WDATA = wd;
        @(posedge CLK);
        t_accept = $time;
        #1;
        REQ = 1'b0; WE = 1'($urandom); FUNCT3 = 3'($urandom); ADDR = $urandom; WDATA = $urandom;
        for (int c = 1; c <= 8; c++) begin
            if (!MEM_CSN) begin
                if (ncyc < 2) begin
                    cadr[ncyc] = MEM_ADDR; cbe[ncyc] = MEM_BE;
                    cdi[ncyc]  = MEM_DI;   cwen[ncyc] = MEM_WEN;
                end
                ncyc++;
            end
            if (DONE) begin
                lat = c; o_err = ERR; o_rdy = READY; o_rdata = RDATA;
                break;
            end
            @(posedge CLK); #1;
        end
        if (lat > 0) begin
            @(posedge CLK); #1;
            done_after = DONE;
            rdy_after  = READY;
        end
    endtask

    task automatic test_reset;
        RSTN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if (READY !== 1'b1 || DONE !== 1'b0 || ERR !== 1'b0 || RDATA !== 32'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got ready=%b done=%b err=%b rdata=%h, want 1 0 0 00000000",
                     READY, DONE, ERR, RDATA);
        end
        total++;
        if (MEM_CSN !== 1'b1 || MEM_WEN !== 1'b1 || MEM_ADDR !== '0 || MEM_BE !== 4'b0 || MEM_DI !== 32'b0) begin
            bad++;
            $display("FAIL reset_mem: got csn=%b wen=%b addr=%h be=%b di=%h, want 1 1 000 0000 00000000",
                     MEM_CSN, MEM_WEN, MEM_ADDR, MEM_BE, MEM_DI);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        exp_rdata = 32'b0;
    endtask

    task automatic test_aligned;
        logic [31:0] want [4];
        logic [2:0]  f3s  [4];
        logic [31:0] adrs [4];
        want = '{32'h80FF7F01, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
        f3s  = '{3'b010, 3'b000, 3'b100, 3'b001};
        adrs = '{32'h14, 32'h17, 32'h17, 32'h16};
        poke(5, 32'h80FF7F01);
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, f3s[i], adrs[i], 32'h0);
            exp_rdata = model_load(adrs[i], f3s[i]);
            total++;
            if (o_rdata !== want[i] || exp_rdata !== want[i]) begin
                bad++;
                $display("FAIL aligned_rdata[%0d]: got %h, want %h", i, o_rdata, want[i]);
            end
            total++;
            if (lat !== 2 || ncyc !== 1 || cadr[0] !== 12'd5 || cbe[0] !== 4'b0 || cwen[0] !== 1'b1) begin
                bad++;
                $display("FAIL aligned_cycle[%0d]: got lat=%0d ncyc=%0d addr=%h be=%b wen=%b, want 2 1 005 0000 1",
                         i, lat, ncyc, cadr[0], cbe[0], cwen[0]);
            end
        end
    endtask

    task automatic test_store;
        do_op(1'b1, 3'b000, 32'h15, 32'h000000AB);
        model_store(32'h15, 3'b000, 32'h000000AB);
        total++;
        if (ncyc !== 1 || cbe[0] !== 4'b0010 || cdi[0][15:8] !== 8'hAB || cwen[0] !== 1'b0 || lat !== 2) begin
            bad++;
            $display("FAIL sb_cycle: got ncyc=%0d be=%b di=%h wen=%b lat=%0d, want 1 0010 ..AB.. 0 2",
                     ncyc, cbe[0], cdi[0], cwen[0], lat);
        end
        do_op(1'b0, 3'b010, 32'h14, 32'h0);
        exp_rdata = model_load(32'h14, 3'b010);
        total++;
        if (o_rdata !== 32'h80FFAB01) begin
            bad++;
            $display("FAIL sb_readback: got %h, want 80FFAB01", o_rdata);
        end
        do_op(1'b1, 3'b001, 32'h16, 32'h00001234);
        model_store(32'h16, 3'b001, 32'h00001234);
        total++;
        if (ncyc !== 1 || cbe[0] !== 4'b1100 || cdi[0][31:16] !== 16'h1234) begin
            bad++;
            $display("FAIL sh_cycle: got ncyc=%0d be=%b di=%h, want 1 1100 1234....", ncyc, cbe[0], cdi[0]);
        end
        do_op(1'b0, 3'b010, 32'h14, 32'h0);
        exp_rdata = model_load(32'h14, 3'b010);
        total++;
        if (o_rdata !== 32'h1234AB01) begin
            bad++;
            $display("FAIL sh_readback: got %h, want 1234AB01", o_rdata);
        end
    endtask

    task automatic test_split;
        poke(5, 32'h44332211);
        poke(6, 32'h88776655);
        do_op(1'b0, 3'b010, 32'h17, 32'h0);
        exp_rdata = model_load(32'h17, 3'b010);
        total++;
        if (o_rdata !== 32'h77665544 || lat !== 3) begin
            bad++;
            $display("FAIL split_lw: got rdata=%h lat=%0d, want 77665544 3", o_rdata, lat);
        end
        total++;
        if (ncyc !== 2 || cadr[0] !== 12'd5 || cadr[1] !== 12'd6 || cbe[0] !== 4'b0 || cbe[1] !== 4'b0) begin
            bad++;
            $display("FAIL split_lw_cycles: got ncyc=%0d addr=%h,%h be=%b,%b, want 2 005,006 0000,0000",
                     ncyc, cadr[0], cadr[1], cbe[0], cbe[1]);
        end
        do_op(1'b0, 3'b001, 32'h17, 32'h0);
        exp_rdata = model_load(32'h17, 3'b001);
        total++;
        if (o_rdata !== 32'h00005544 || lat !== 3) begin
            bad++;
            $display("FAIL split_lh: got rdata=%h lat=%0d, want 00005544 3", o_rdata, lat);
        end
    endtask

    task automatic test_wrap;
        do_op(1'b1, 3'b010, 32'h3FFE, 32'hDEADBEEF);
        model_store(32'h3FFE, 3'b010, 32'hDEADBEEF);
        total++;
        if (ncyc !== 2 || cadr[0] !== 12'hFFF || cbe[0] !== 4'b1100 || cdi[0][31:16] !== 16'hBEEF) begin
            bad++;
            $display("FAIL wrap_cycle1: got ncyc=%0d addr=%h be=%b di=%h, want 2 FFF 1100 BEEF....",
                     ncyc, cadr[0], cbe[0], cdi[0]);
        end
        total++;
        if (cadr[1] !== 12'h000 || cbe[1] !== 4'b0011 || cdi[1][15:0] !== 16'hDEAD || lat !== 3) begin
            bad++;
            $display("FAIL wrap_cycle2: got addr=%h be=%b di=%h lat=%0d, want 000 0011 ....DEAD 3",
                     cadr[1], cbe[1], cdi[1], lat);
        end
        do_op(1'b0, 3'b010, 32'h3FFE, 32'h0);
        exp_rdata = model_load(32'h3FFE, 3'b010);
        total++;
        if (o_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wrap_readback: got %h, want DEADBEEF", o_rdata);
        end
    endtask

    task automatic test_illegal;
        do_op(1'b0, 3'b011, 32'h14, 32'h0);
        total++;
        if (lat !== 1 || o_err !== 1'b1 || ncyc !== 0 || o_rdata !== exp_rdata || o_rdy !== 1'b0) begin
            bad++;
            $display("FAIL illegal_011: got lat=%0d err=%b ncyc=%0d rdata=%h ready=%b, want 1 1 0 %h 0",
                     lat, o_err, ncyc, o_rdata, o_rdy, exp_rdata);
        end
        do_op(1'b1, 3'b100, 32'h14, 32'hFFFFFFFF);
        total++;
        if (lat !== 1 || o_err !== 1'b1 || ncyc !== 0 || o_rdata !== exp_rdata || rdy_after !== 1'b1) begin
            bad++;
            $display("FAIL illegal_sbu: got lat=%0d err=%b ncyc=%0d rdata=%h ready_after=%b, want 1 1 0 %h 1",
                     lat, o_err, ncyc, o_rdata, rdy_after, exp_rdata);
        end
    endtask

    task automatic test_busy_req;
        int ndone;
        int ncsn;
        int badaddr;
        ndone = 0; ncsn = 0; badaddr = 0;
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b0; FUNCT3 = 3'b010; ADDR = 32'h14; WDATA = 32'h0;
        @(posedge CLK); #1;
        ADDR = 32'h40;
        for (int c = 1; c <= 6; c++) begin
            if (!MEM_CSN) begin
                ncsn++;
                if (MEM_ADDR !== 12'd5) badaddr++;
            end
            if (DONE) begin
                ndone++;
                o_rdata = RDATA;
                REQ = 1'b0;
            end
            @(posedge CLK); #1;
        end
        REQ = 1'b0;
        exp_rdata = model_load(32'h14, 3'b010);
        total++;
        if (ndone !== 1 || ncsn !== 1 || badaddr !== 0 || o_rdata !== exp_rdata) begin
            bad++;
            $display("FAIL busy_req: got done=%0d csn_cycles=%0d wrong_addr=%0d rdata=%h, want 1 1 0 %h",
                     ndone, ncsn, badaddr, o_rdata, exp_rdata);
        end
    endtask

    task automatic test_back_to_back;
        time t1;
        do_op(1'b0, 3'b010, 32'h20, 32'h0);
        t1 = t_accept;
        exp_rdata = model_load(32'h20, 3'b010);
        do_op(1'b0, 3'b010, 32'h24, 32'h0);
        exp_rdata = model_load(32'h24, 3'b010);
        total++;
        if (t_accept - t1 !== 30 || o_rdata !== exp_rdata) begin
            bad++;
            $display("FAIL back_to_back: got spacing=%0t rdata=%h, want 30 %h", t_accept - t1, o_rdata, exp_rdata);
        end
    endtask

    task automatic test_random;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] m;
        int          elat;
        int          diffs;
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            a[13:2] = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4093, 4095)) : 12'($urandom_range(0, 7));
            wd = $urandom;
            do_op(we, f3, a, wd);
            if (is_legal(we, f3)) begin
                model_cycles(we, f3, a, wd);
                elat = enc + 1;
                if (we) model_store(a, f3, wd);
                else    exp_rdata = model_load(a, f3);
            end else begin
                enc  = 0;
                elat = 1;
            end
            total++;
            if (lat !== elat || o_err !== !is_legal(we, f3) || ncyc !== enc) begin
                bad++;
                $display("FAIL rnd_ctrl[%0d] we=%b f3=%b a=%h: got lat=%0d err=%b ncyc=%0d, want %0d %b %0d",
                         n, we, f3, a, lat, o_err, ncyc, elat, !is_legal(we, f3), enc);
            end
            for (int j = 0; j < enc && j < ncyc && j < 2; j++) begin
                m = {{8{ebe[j][3]}}, {8{ebe[j][2]}}, {8{ebe[j][1]}}, {8{ebe[j][0]}}};
                total++;
                if (cadr[j] !== eadr[j] || cbe[j] !== ebe[j] || cwen[j] !== !we || (cdi[j] & m) !== (edi[j] & m)) begin
                    bad++;
                    $display("FAIL rnd_cycle[%0d.%0d]: got addr=%h be=%b wen=%b di=%h, want %h %b %b %h",
                             n, j, cadr[j], cbe[j], cwen[j], cdi[j] & m, eadr[j], ebe[j], !we, edi[j] & m);
                end
            end
            total++;
            if (o_rdata !== exp_rdata || rdy_after !== 1'b1 || done_after !== 1'b0 || o_rdy !== 1'b0) begin
                bad++;
                $display("FAIL rnd_resp[%0d]: got rdata=%h ready@done=%b ready_after=%b done_after=%b, want %h 0 1 0",
                         n, o_rdata, o_rdy, rdy_after, done_after, exp_rdata);
            end
        end
        diffs = 0;
        for (int w = 0; w < 4096; w++) begin
            if (sram[w] !== ref_mem[w]) diffs++;
        end
        total++;
        if (diffs !== 0) begin
            bad++;
            $display("FAIL rnd_memory: got %0d differing words, want 0", diffs);
        end
    endtask

    task automatic test_reset_mid;
        poke(9, 32'hCAFEF00D);
        poke(10, 32'h13572468);
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b0; FUNCT3 = 3'b010; ADDR = 32'h26;
        @(posedge CLK); #1;
        REQ = 1'b0;
        @(posedge CLK); #1;
        total++;
        if (MEM_CSN !== 1'b0 || MEM_ADDR !== 12'd10 || MEM_BE !== 4'b0) begin
            bad++;
            $display("FAIL rst_mid_acc1: got csn=%b addr=%h be=%b, want 0 00A 0000", MEM_CSN, MEM_ADDR, MEM_BE);
        end
        @(negedge CLK);
        RSTN = 1'b0;
        @(posedge CLK); #1;
        total++;
        if (MEM_CSN !== 1'b1 || MEM_BE !== 4'b0 || READY !== 1'b1 || RDATA !== 32'b0 || DONE !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_state: got csn=%b be=%b ready=%b rdata=%h done=%b, want 1 0000 1 00000000 0",
                     MEM_CSN, MEM_BE, READY, RDATA, DONE);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        exp_rdata = 32'b0;
        @(posedge CLK); #1;
        total++;
        if (DONE !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_nodone: got done=%b, want 0", DONE);
        end
        do_op(1'b0, 3'b010, 32'h24, 32'h0);
        exp_rdata = model_load(32'h24, 3'b010);
        total++;
        if (o_rdata !== 32'hCAFEF00D || lat !== 2) begin
            bad++;
            $display("FAIL rst_mid_after: got rdata=%h lat=%0d, want CAFEF00D 2", o_rdata, lat);
        end
    endtask

    initial begin
        RSTN = 1'b0; REQ = 1'b0; WE = 1'b0; FUNCT3 = 3'b000; ADDR = 32'b0; WDATA = 32'b0;
        exp_rdata = 32'b0;
        for (int w = 0; w < 4096; w++) begin
            sram[w]    = $urandom;
            ref_mem[w] = sram[w];
        end
        test_reset;
        test_aligned;
        test_store;
        test_split;
        test_wrap;
        test_illegal;
        test_busy_req;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller sitting directly upstream of the data SP_SRAM.
- Accepts one byte-addressed RISC-V load/store request at a time from the execute stage.
- Converts it into word-addressed SRAM cycles (CSN/WEN/BE/DI) and returns sign- or zero-extended load data.
- Accesses that cross a word boundary are split into two consecutive SRAM cycles.

Parameters:
- AWIDTH, 12, SRAM word-address width; byte address bits [AWIDTH+1:2] select the word, and word addresses wrap modulo 2^AWIDTH.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RSTN  input  1  synchronous active-low reset.
- REQ  input  1  request valid; taken only when READY=1.
- WE  input  1  1=store, 0=load.
- FUNCT3  input  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ADDR  input  32  byte address.
- WDATA  input  32  store data; low byte/half used for SB/SH.
- READY  output  1  high in IDLE.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  valid with DONE; illegal FUNCT3.
- RDATA  output  32  load result; held until the next load DONE.
- MEM_CSN  output  1  SRAM chip select, active low.
- MEM_WEN  output  1  SRAM write enable, active low.
- MEM_ADDR  output  AWIDTH  SRAM word address.
- MEM_BE  output  4  SRAM byte enables.
- MEM_DI  output  32  SRAM write data.
- MEM_DOUT  input  32  SRAM read data; combinational from MEM_ADDR.

Behaviour:
- Reset (RSTN=0 at posedge):
  - State=IDLE, READY=1, DONE=0, ERR=0, RDATA=0.
  - MEM_CSN=1, MEM_WEN=1, MEM_ADDR=0, MEM_BE=0, MEM_DI=0.
- Reset mid-operation:
  - The operation is aborted and no DONE is issued.
  - An SRAM cycle already driven before the reset edge completes at that cycle's negedge.
- All MEM_* outputs are registered and change only at posedge.
- Accept: REQ & READY at posedge k registers WE, FUNCT3, ADDR and WDATA. The state leaves IDLE at that edge.
- Derived values:
  - off = ADDR[1:0].
  - size mask: 1 (byte), 3 (half), F (word).
  - 8-bit lane mask m = size_mask << off.
  - split = (m[7:4] != 0).
- Request-side restrictions:
  - REQ while READY=0 is ignored.
  - DONE and READY are never high in the same cycle.
- States: IDLE -> ACC0 -> (ACC1 if split) -> RESP -> IDLE.
  - Illegal FUNCT3 (011, 110, 111; or 100/101 with WE=1) goes IDLE -> RESP with ERR=1.
  - An illegal request makes no SRAM cycle: MEM_CSN stays 1.
- ACC0 (cycle k+1):
  - MEM_CSN=0, MEM_ADDR=word(ADDR).
  - Store: MEM_WEN=0, MEM_BE=m[3:0], MEM_DI=(WDATA<<8*off)[31:0].
  - Load: MEM_WEN=1, MEM_BE=4'b0000. BE must be 0 on every read cycle because the SRAM writes enabled bytes whenever CSN is low.
  - Load: MEM_DOUT is captured into W0 at the closing posedge.
- ACC1 (split only):
  - MEM_ADDR = word(ADDR)+1 modulo 2^AWIDTH; word 2^AWIDTH-1 wraps to 0.
  - Store: MEM_BE=m[7:4], MEM_DI=(WDATA<<8*off)[63:32] of the 64-bit shift.
  - Load: MEM_BE=0; MEM_DOUT is captured into W1.
- RESP:
  - MEM_CSN=1, MEM_WEN=1, MEM_BE=0.
  - DONE=1 for exactly one cycle; READY=0.
  - For loads, RDATA is updated at the edge entering RESP. Source is ({W1,W0} >> 8*off), W1=0 if not split.
  - RDATA extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes all 32 bits.
  - Stores and errors leave RDATA unchanged.
- Latency, request accepted at edge k:
  - Aligned: DONE in cycle k+2.
  - Split: DONE in cycle k+3.
  - Error: DONE+ERR in cycle k+1.
  - READY returns in the cycle after DONE; back-to-back throughput is one request per 3 cycles when aligned.
- Outside ACC0/ACC1: MEM_CSN=1 and MEM_BE=0.

Test Plan:
- Aligned load/store:
  - Preload word 5=0x80FF7F01.
  - LW ADDR=0x14 -> one CSN-low cycle, MEM_ADDR=5, MEM_BE=0, DONE at k+2, RDATA=0x80FF7F01.
  - LB 0x17 -> 0xFFFFFF80; LBU 0x17 -> 0x00000080; LH 0x16 -> 0xFFFF80FF.
- Byte/half stores:
  - SB WDATA=0xAB to 0x15 -> MEM_BE=0010, MEM_DI[15:8]=0xAB; subsequent LW 0x14 returns 0x80FFAB01.
  - SH 0x1234 to 0x16 -> BE=1100; LW then returns 0x1234AB01.
- Split load:
  - Words 5=0x44332211, 6=0x88776655.
  - LW 0x17 -> two CSN-low cycles at addr 5 then 6, BE=0 both, DONE at k+3, RDATA=0x77665544.
  - LH 0x17 -> RDATA=0x00005544.
- Split store with wrap:
  - AWIDTH=12, SW 0xDEADBEEF to byte 0x3FFE.
  - Cycle 1: MEM_ADDR=0xFFF, BE=1100, DI[31:16]=0xBEEF.
  - Cycle 2: MEM_ADDR=0x000, BE=0011, DI[15:0]=0xDEAD.
- Illegal and ignored requests:
  - FUNCT3=011 -> DONE=ERR=1 at k+1, MEM_CSN never low, RDATA unchanged.
  - REQ held during busy cycles -> ignored until READY, then accepted exactly once.
- Reset mid-split-load:
  - RSTN=0 in the ACC1 cycle -> next cycle MEM_CSN=1, BE=0, READY=1, RDATA=0, no DONE.
  - A new LW after reset completes normally.
